// File: rtl/multiplier.sv
// Shift-add reconstruction unit: dividend = quotientin * divisorin + remainderin over up to eight add/shift steps.
// Optional MULTIPLIER_EARLY_EXIT_EN ends RUN as soon as no multiplier bits remain.
module multiplier (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  quotientin,
   input  logic [6:0]  divisorin,
   input  logic [6:0]  remainderin,
   input  logic        start,
   output logic [14:0] dividend,
   output logic        valid,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e      state_q, state_d;
   logic [14:0] acc_q, acc_d;
   logic [14:0] mcand_q, mcand_d;
   logic [7:0]  mplier_q, mplier_d;
   logic [2:0]  count_q, count_d;
   logic        err_next_q, err_next_d;
   logic [14:0] dividend_q, dividend_d;
   logic        err_q, err_d;
   logic        valid_q, valid_d;
   logic        last_step;

`ifdef MULTIPLIER_EARLY_EXIT_EN
   assign last_step = (count_q == 3'd7) || (mplier_q[7:1] == 7'd0);
`else
   assign last_step = (count_q == 3'd7);
`endif

   // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         count_q    <= '0;
         err_next_q <= 1'b0;
         dividend_q <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         count_q    <= count_d;
         err_next_q <= err_next_d;
         dividend_q <= dividend_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
      end
   end

   // NOTE: every signal gets a hold default first, so no path through this block infers a latch.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      count_d    = count_q;
      err_next_d = err_next_q;
      dividend_d = dividend_q;
      err_d      = err_q;
      valid_d    = valid_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               acc_d      = {8'b0, remainderin};
               mcand_d    = {8'b0, divisorin};
               mplier_d   = quotientin;
               count_d    = 3'd0;
               err_next_d = (remainderin >= divisorin);
               valid_d    = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            // Maximum 255*127+126 fits in 15 bits, so the sum never wraps.
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 3'd1;
            if (last_step) begin
               dividend_d = acc_d;
               err_d      = err_next_q;
               valid_d    = 1'b1;
               state_d    = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dividend = dividend_q;
      err      = err_q;
      valid    = valid_q;
   end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: vector table, start/reset corner sequences and divider loop-back,
// with expected results queued at load and compared when valid rises.
module tb_multiplier;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  quotientin;
   logic [6:0]  divisorin;
   logic [6:0]  remainderin;
   logic        start;
   logic [14:0] dividend;
   logic        valid;
   logic        err;

   multiplier dut (
      .clk         (clk),
      .reset       (reset),
      .quotientin  (quotientin),
      .divisorin   (divisorin),
      .remainderin (remainderin),
      .start       (start),
      .dividend    (dividend),
      .valid       (valid),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  q;
      logic [6:0]  d;
      logic [6:0]  r;
      logic [14:0] exp_div;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [14:0] div;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic int exp_lat(input logic [7:0] q);
      int l;
      l = 8;
`ifdef MULTIPLIER_EARLY_EXIT_EN
      l = 1;
      for (int i = 0; i < 8; i++) if (q[i]) l = i + 1;
`endif
      return l;
   endfunction

   // Waits (bounded) for valid, then compares latency, result, err and mid-run hold of dividend.
   task automatic collect(input string name, input logic [14:0] prev);
      exp_t e;
      int   lat;
      bit   stable;
      e      = sb.pop_front();
      lat    = 0;
      stable = 1'b1;
      while (valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
         if (valid !== 1'b1 && dividend !== prev) stable = 1'b0;
      end
      check({name, "_lat"}, lat, e.lat);
      check({name, "_div"}, {17'b0, dividend}, {17'b0, e.div});
      check({name, "_err"}, {31'b0, err}, {31'b0, e.err});
      check({name, "_hold"}, {31'b0, stable}, 32'd1);
   endtask

   task automatic run_op(input string name, input logic [7:0] q, input logic [6:0] d,
                         input logic [6:0] r, input logic [14:0] ediv, input logic eerr);
      logic [14:0] prev;
      @(negedge clk);
      quotientin  = q;
      divisorin   = d;
      remainderin = r;
      start       = 1'b1;
      sb.push_back('{ediv, eerr, exp_lat(q)});
      @(negedge clk);
      start       = 1'b0;
      quotientin  = 8'($urandom);
      divisorin   = 7'($urandom);
      remainderin = 7'($urandom);
      check({name, "_valid_low"}, {31'b0, valid}, 32'd0);
      prev = dividend;
      collect(name, prev);
   endtask

   vec_t vecs[9];

   initial begin
      int k;
      int np;
      int first_k;
      logic [7:0] a;
      logic [6:0] dv;

      vecs[0] = '{8'h0A, 7'h07, 7'h03, 15'h0049, 1'b0};
      vecs[1] = '{8'hFF, 7'h7F, 7'h7E, 15'h7EFF, 1'b0};
      vecs[2] = '{8'h05, 7'h04, 7'h04, 15'h0018, 1'b1};
      vecs[3] = '{8'h03, 7'h00, 7'h00, 15'h0000, 1'b1};
      vecs[4] = '{8'h00, 7'h55, 7'h12, 15'h0012, 1'b0};
      vecs[5] = '{8'h01, 7'h7F, 7'h00, 15'h007F, 1'b0};
      vecs[6] = '{8'h80, 7'h01, 7'h00, 15'h0080, 1'b0};
      vecs[7] = '{8'h80, 7'h7F, 7'h7F, 15'h3FFF, 1'b1};
      vecs[8] = '{8'h00, 7'h00, 7'h7F, 15'h007F, 1'b1};

      reset = 1'b1; start = 1'b0;
      quotientin = '0; divisorin = '0; remainderin = '0;
      repeat (2) @(negedge clk);
      check("rst_div",   {17'b0, dividend}, 32'd0);
      check("rst_valid", {31'b0, valid},    32'd0);
      check("rst_err",   {31'b0, err},      32'd0);
      reset = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].exp_div, vecs[i].exp_err);

      // start held high: reload only in DONE, one valid pulse every 9 cycles.
      @(negedge clk);
      quotientin = 8'h80; divisorin = 7'h01; remainderin = 7'h00; start = 1'b1;
      sb.push_back('{15'h0080, 1'b0, 8});
      sb.push_back('{15'h3FFF, 1'b1, 8});
      sb.push_back('{15'h3FFF, 1'b1, 8});
      @(negedge clk);
      quotientin = 8'h80; divisorin = 7'h7F; remainderin = 7'h7F;
      np = 0;
      for (k = 1; k <= 26; k++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            exp_t e;
            e = sb.pop_front();
            check("held_pulse_at", k, 9 * np + 8);
            check("held_div", {17'b0, dividend}, {17'b0, e.div});
            check("held_err", {31'b0, err}, {31'b0, e.err});
            np++;
            if (sb.size() == 0) break;
         end
      end
      start = 1'b0;
      check("held_pulses", np, 3);
      sb.delete();

      // start asserted during RUN must be ignored.
      @(negedge clk);
      quotientin = 8'h0A; divisorin = 7'h07; remainderin = 7'h03; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      first_k = -1;
      for (k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 3) begin
            start = 1'b1; quotientin = 8'hFF; divisorin = 7'h7F; remainderin = 7'h7E;
         end else begin
            start = 1'b0;
         end
         if (valid === 1'b1 && first_k < 0) first_k = k;
      end
      check("runstart_lat", first_k, exp_lat(8'h0A));
      check("runstart_div", {17'b0, dividend}, 32'h49);
      check("runstart_valid_hold", {31'b0, valid}, 32'd1);

      // Reset after four RUN steps clears everything; next op completes normally.
      run_op("pre_rst", 8'h05, 7'h04, 7'h04, 15'h0018, 1'b1);
      @(negedge clk);
      quotientin = 8'hFF; divisorin = 7'h7F; remainderin = 7'h7E; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_div",   {17'b0, dividend}, 32'd0);
      check("midrst_valid", {31'b0, valid},    32'd0);
      check("midrst_err",   {31'b0, err},      32'd0);
      repeat (10) @(negedge clk);
      check("midrst_idle_valid", {31'b0, valid}, 32'd0);
      run_op("post_rst", 8'h0A, 7'h07, 7'h03, 15'h0049, 1'b0);

      // Loop-back through a behavioural divider.
      for (int i = 0; i < 1000; i++) begin
         a  = 8'($urandom_range(0, 255));
         dv = 7'($urandom_range(1, 127));
         run_op("loop", 8'(a / dv), dv, 7'(a % dv), {7'b0, a}, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
